// File: rtl/key_conditioner.sv
// Push-button front end: per-key 2-flop synchronizer, debounce FSM and
// registered level / press / release / long-press strobes in the clock domain.

module key_conditioner_chan #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic clock,
    input  logic reset_n,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_CYCLES);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_CYCLES - 2);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        REL_CHK
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    sync_q, sync_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          ks;

    // Synchronizer resets to "released" so a key held through reset is re-detected.
    assign ks = sync_q[1];

    always_comb begin
        sync_d      = {sync_q[0], key_n};
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            RELEASED: begin
                if (!ks) begin
                    state_d = PRESS_CHK;
                    dcnt_d  = '0;
                end
            end
            PRESS_CHK: begin
                if (ks) begin
                    state_d = RELEASED;
                end else if (dcnt_q == DEB_MAX) begin
                    state_d     = PRESSED;
                    press_d     = 1'b1;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            PRESSED: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                // Fire on the step into the final count; long_done keeps it to one per press.
                if (hold_q == HOLD_PRE && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (ks) begin
                    state_d = REL_CHK;
                    dcnt_d  = '0;
                end
            end
            REL_CHK: begin
                if (!ks) begin
                    state_d = PRESSED;
                end else if (dcnt_q == DEB_MAX) begin
                    state_d   = RELEASED;
                    release_d = 1'b1;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = RELEASED;
        endcase
        level_d = (state_d == PRESSED) || (state_d == REL_CHK);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= 2'b11;
            state_q     <= RELEASED;
            dcnt_q      <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            sync_q      <= sync_d;
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign key_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
endmodule

module key_conditioner #(
    parameter int NUM_KEYS        = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse
);
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
        key_conditioner_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_chan (
            .clock        (clock),
            .reset_n      (reset_n),
            .key_n        (key[gi]),
            .key_level    (key_level[gi]),
            .press_pulse  (press_pulse[gi]),
            .release_pulse(release_pulse[gi]),
            .long_pulse   (long_pulse[gi])
        );
    end
endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: directed scenarios plus random key
// activity, checked cycle by cycle against a run-length reference model.

module tb_key_conditioner;
    localparam int NK = 2;
    localparam int D  = 4;
    localparam int L  = 20;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] key_level, press_pulse, release_pulse, long_pulse;

    key_conditioner #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .key          (key),
        .key_level    (key_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse)
    );

    always #5 clock = ~clock;

    typedef struct {
        int            cyc;
        logic [NK-1:0] lvl, pr, rl, lg;
    } exp_t;

    exp_t q[$];
    int   checks = 0, passed = 0, cyc = 0;
    bit   stim_done = 0;

    // Reference model: raw key delayed by two samples; a change is accepted once
    // the delayed key disagrees with the accepted level for D+1 consecutive samples.
    bit m_d1[NK], m_d2[NK], m_lvl[NK], m_ldone[NK];
    int m_run[NK], m_hold[NK];

    task automatic model_reset();
        for (int i = 0; i < NK; i++) begin
            m_d1[i] = 1; m_d2[i] = 1; m_lvl[i] = 0; m_ldone[i] = 0;
            m_run[i] = 0; m_hold[i] = 0;
        end
    endtask

    task automatic step(input logic [NK-1:0] k, input logic rn);
        exp_t e;
        bit ks;
        @(negedge clock);
        key = k;
        reset_n = rn;
        cyc++;
        e.cyc = cyc; e.lvl = '0; e.pr = '0; e.rl = '0; e.lg = '0;
        if (!rn) begin
            model_reset();
        end else begin
            for (int i = 0; i < NK; i++) begin
                ks = m_d2[i];
                m_d2[i] = m_d1[i];
                m_d1[i] = k[i];
                if (!m_lvl[i]) begin
                    m_run[i] = ks ? 0 : m_run[i] + 1;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = 1; m_run[i] = 0; m_hold[i] = 0; m_ldone[i] = 0;
                        e.pr[i] = 1'b1;
                    end
                end else begin
                    // Hold time advances only while no release is pending.
                    if (m_run[i] == 0) begin
                        if (m_hold[i] < L - 1) m_hold[i]++;
                        if (m_hold[i] == L - 1 && !m_ldone[i]) begin
                            m_ldone[i] = 1;
                            e.lg[i] = 1'b1;
                        end
                    end
                    m_run[i] = ks ? m_run[i] + 1 : 0;
                    if (m_run[i] == D + 1) begin
                        m_lvl[i] = 0; m_run[i] = 0;
                        e.rl[i] = 1'b1;
                    end
                end
                e.lvl[i] = m_lvl[i];
            end
        end
        q.push_back(e);
    endtask

    task automatic repeat_step(input logic [NK-1:0] k, input logic rn, input int n);
        for (int j = 0; j < n; j++) step(k, rn);
    endtask

    // Monitor: outputs are valid every cycle, so one expected record per edge.
    initial begin
        exp_t e;
        @(negedge clock);
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if ({key_level, press_pulse, release_pulse, long_pulse} ==
                    {e.lvl, e.pr, e.rl, e.lg})
                    passed++;
                else
                    $display("FAIL outputs cyc=%0d got lvl=%b pr=%b rl=%b lg=%b exp lvl=%b pr=%b rl=%b lg=%b",
                             e.cyc, key_level, press_pulse, release_pulse, long_pulse,
                             e.lvl, e.pr, e.rl, e.lg);
            end else if (!stim_done) begin
                checks++;
                $display("FAIL scoreboard_underflow time=%0t got empty exp record", $time);
            end
        end
    end

    initial begin
        int rem[NK];
        logic [NK-1:0] kv;
        model_reset();
        repeat_step(2'b11, 1'b0, 3);
        repeat_step(2'b11, 1'b1, 3);
        // Clean press on key0
        repeat_step(2'b10, 1'b1, 10);
        repeat_step(2'b11, 1'b1, 12);
        // Bounce on key1
        for (int j = 0; j < 5; j++) begin
            repeat_step(2'b01, 1'b1, 2);
            step(2'b11, 1'b1);
        end
        repeat_step(2'b11, 1'b1, 12);
        // Long press
        repeat_step(2'b10, 1'b1, 40);
        repeat_step(2'b11, 1'b1, 12);
        // Release glitch during press, then long press completes
        repeat_step(2'b10, 1'b1, 10);
        repeat_step(2'b11, 1'b1, 2);
        repeat_step(2'b10, 1'b1, 30);
        repeat_step(2'b11, 1'b1, 12);
        // Simultaneous keys, independent releases
        repeat_step(2'b00, 1'b1, 10);
        repeat_step(2'b01, 1'b1, 8);
        repeat_step(2'b11, 1'b1, 12);
        // Reset during PRESS_CHK and during PRESSED with key0 held
        repeat_step(2'b10, 1'b1, 4);
        repeat_step(2'b10, 1'b0, 2);
        repeat_step(2'b10, 1'b1, 10);
        repeat_step(2'b10, 1'b0, 2);
        repeat_step(2'b10, 1'b1, 10);
        repeat_step(2'b11, 1'b1, 12);
        // Random key activity with occasional resets
        kv = '1;
        for (int i = 0; i < NK; i++) rem[i] = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NK; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    kv[i] = ~kv[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 35))
                                                          : int'($urandom_range(1, 8));
                end
            end
            step(kv, ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
        end
        repeat_step(2'b11, 1'b1, 12);
        @(posedge clock);
        #2;
        stim_done = 1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain got %0d records left exp 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
